// File: rtl/polyz_unpack_stream.sv
`default_nettype none
// ============================================================================
// Module      : polyz_unpack_stream
// Description : Streams packed GAMMA1 z-fields (18 or 20 bits) out of a byte
//               stream and emits one signed coefficient per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module polyz_unpack_stream #(
    parameter int N        = 256,
    parameter int IN_BYTES = 4,
    parameter int BUF_W    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [8*IN_BYTES-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [31:0]             out_coeff,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int c_IDX_W  = $clog2(N);
    localparam int c_EXT_W  = c_IDX_W + 1;
    localparam int c_IN_W   = 8 * IN_BYTES;
    localparam int c_FILL_W = $clog2(BUF_W + 1);
    localparam int c_TOT0   = N * 18 / 8;
    localparam int c_TOT1   = N * 20 / 8;
    localparam int c_BYTE_W = $clog2(c_TOT1 + IN_BYTES + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic                r_mode;
    logic [BUF_W-1:0]    r_buf;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_BYTE_W-1:0] r_bytes;
    logic [c_EXT_W-1:0]  r_ext;
    logic [31:0]         r_coeff;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_valid;
    logic                r_last;

    logic [c_FILL_W-1:0] w_zw;
    logic [c_BYTE_W-1:0] w_total;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_extract;
    logic                w_last_hs;
    logic [19:0]         w_z;
    logic [31:0]         w_gamma;
    logic [31:0]         w_coeff;
    logic [BUF_W-1:0]    w_buf_sh;
    logic [c_FILL_W-1:0] w_fill_sh;
    logic [BUF_W-1:0]    w_in_ext;
    logic [BUF_W-1:0]    w_buf_nxt;
    logic [c_FILL_W-1:0] w_fill_nxt;

    assign w_zw    = r_mode ? c_FILL_W'(20) : c_FILL_W'(18);
    assign w_total = r_mode ? c_BYTE_W'(c_TOT1) : c_BYTE_W'(c_TOT0);

    assign w_in_ready = (r_state == c_ST_RUN)
                     && (r_fill <= c_FILL_W'(BUF_W - c_IN_W))
                     && (r_bytes < w_total);
    assign w_accept   = w_in_ready && in_valid;

    // The extraction counter stops at N so nothing follows the last index.
    assign w_extract = (r_state == c_ST_RUN) && (r_fill >= w_zw)
                    && (r_ext < c_EXT_W'(N)) && (!r_valid || out_ready);
    assign w_last_hs = r_valid && out_ready && r_last;

    assign w_z     = r_mode ? r_buf[19:0] : {2'b00, r_buf[17:0]};
    assign w_gamma = r_mode ? 32'h0008_0000 : 32'h0002_0000;
    assign w_coeff = w_gamma - {12'd0, w_z};

    // Bits above fill are always zero, so new data can be OR-ed in place.
    assign w_buf_sh   = w_extract ? (r_buf >> w_zw) : r_buf;
    assign w_fill_sh  = w_extract ? (r_fill - w_zw) : r_fill;
    assign w_in_ext   = {{(BUF_W - c_IN_W){1'b0}}, in_data};
    assign w_buf_nxt  = w_accept ? (w_buf_sh | (w_in_ext << w_fill_sh)) : w_buf_sh;
    assign w_fill_nxt = w_accept ? (w_fill_sh + c_FILL_W'(c_IN_W)) : w_fill_sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_mode  <= 1'b0;
            r_buf   <= '0;
            r_fill  <= '0;
            r_bytes <= '0;
            r_ext   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_RUN;
                        r_mode  <= mode;
                        r_buf   <= '0;
                        r_fill  <= '0;
                        r_bytes <= '0;
                        r_ext   <= '0;
                    end
                end
                c_ST_RUN: begin
                    r_buf  <= w_buf_nxt;
                    r_fill <= w_fill_nxt;
                    if (w_accept) begin
                        r_bytes <= r_bytes + c_BYTE_W'(IN_BYTES);
                    end
                    if (w_extract) begin
                        r_ext <= r_ext + 1'b1;
                    end
                    if (w_last_hs) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_coeff <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_extract) begin
            r_coeff <= w_coeff;
            r_idx   <= r_ext[c_IDX_W-1:0];
            r_valid <= 1'b1;
            r_last  <= (r_ext == c_EXT_W'(N - 1));
        end else if (out_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_coeff = r_coeff;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign busy      = (r_state == c_ST_RUN);
    assign done      = (r_state == c_ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_polyz_unpack_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_polyz_unpack_stream
// Description : Directed/random bench for polyz_unpack_stream with a bit-level
//               reference model of the packed z-field stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polyz_unpack_stream;

    localparam int N        = 256;
    localparam int IN_BYTES = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  mode;
    logic [8*IN_BYTES-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           out_coeff;
    logic [7:0]            out_idx;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    int errors = 0;
    int checks = 0;

    polyz_unpack_stream #(.N(N), .IN_BYTES(IN_BYTES), .BUF_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_coeff (out_coeff),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_out_coeff"}, out_coeff,      32'd0);
        chk({tag, "_out_idx"},   32'(out_idx),   32'd0);
    endtask

    // kind: 0 all 0x00, 1 all 0xFF, 2 leading 0x01 then zeros, 3 random
    task automatic run_poly(input bit md, input int kind, input bit rnd,
                            input bit poke, input int abort_at);
        byte unsigned strm[$];
        logic [31:0]  expq[$];
        logic [31:0]  gamma;
        logic [31:0]  prev_coeff;
        logic [31:0]  prev_idx;
        int           zw, total, wp, got, accepted, cyc;
        bit           in_hs, out_hs, stalled, finished;

        zw    = md ? 20 : 18;
        total = N * zw / 8;
        gamma = md ? 32'd524288 : 32'd131072;
        for (int i = 0; i < total; i++) begin
            case (kind)
                0:       strm.push_back(8'h00);
                1:       strm.push_back(8'hFF);
                2:       strm.push_back((i == 0) ? 8'h01 : 8'h00);
                default: strm.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        // Coefficient k is GAMMA1 minus the zw-bit field at stream bit k*zw.
        for (int k = 0; k < N; k++) begin
            int z;
            z = 0;
            for (int b = 0; b < zw; b++) begin
                int p;
                p = k * zw + b;
                if (((strm[p / 8] >> (p % 8)) & 1) != 0) z |= (1 << b);
            end
            expq.push_back(gamma - 32'(z));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        mode      = md;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = !md;

        wp = 0; got = 0; accepted = 0; stalled = 0; finished = 0;
        prev_coeff = '0; prev_idx = '0;
        for (cyc = 0; cyc < 20000 && !finished; cyc++) begin
            start     = poke && (cyc == 10);
            in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            for (int j = 0; j < IN_BYTES; j++) begin
                int bi;
                bi = wp * IN_BYTES + j;
                in_data[8*j +: 8] = (bi < total) ? strm[bi] : 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            if (out_valid) begin
                if (got < N) begin
                    chk("coeff", out_coeff, expq[got]);
                    chk("idx", 32'(out_idx), 32'(got));
                    chk("last", 32'(out_last), 32'(got == N - 1));
                end else begin
                    chk("extra_output", 32'(out_valid), 32'd0);
                end
            end
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_coeff", out_coeff, prev_coeff);
                chk("stall_idx", 32'(out_idx), prev_idx);
            end
            if (accepted >= total) chk("in_ready_after_total", 32'(in_ready), 32'd0);
            in_hs      = in_valid && in_ready;
            out_hs     = out_valid && out_ready;
            stalled    = out_valid && !out_ready;
            prev_coeff = out_coeff;
            prev_idx   = 32'(out_idx);
            @(posedge clk); #1;
            start = 1'b0;
            if (in_hs) begin
                wp++;
                accepted += IN_BYTES;
            end
            if (out_hs) begin
                got++;
                if (got == N) finished = 1;
                if (got == abort_at) begin
                    rst      = 1'b1;
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    @(negedge clk);
                    chk_idle_outputs("abort");
                    @(posedge clk); #1;
                    return;
                end
            end
        end

        chk("coeff_count", 32'(got), 32'(N));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = $urandom;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_in_ready", 32'(in_ready), 32'd0);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("bytes_accepted", 32'(accepted), 32'(total));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_poly(1'b1, 0, 1'b0, 1'b0, -1);
        run_poly(1'b1, 1, 1'b0, 1'b0, -1);
        run_poly(1'b0, 2, 1'b0, 1'b0, -1);
        run_poly(1'b0, 3, 1'b1, 1'b0, -1);
        run_poly(1'b0, 3, 1'b1, 1'b0, 101);
        run_poly(1'b1, 3, 1'b1, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
